// File: rtl/hdmi_audio_packetizer.sv
// HDMI Audio Sample Packet builder.
// Buffers stereo 16-bit samples in a small FIFO, groups up to four of them
// into one Audio Sample Packet (type 0x02, layout 0) with IEC60958
// channel-status, parity and block-start flags, and offers the packet to the
// data-island scheduler through a valid/ready handshake.
module hdmi_audio_packetizer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] FS_CODE    = 4'b1110,
  parameter logic [3:0] WL_CODE    = 4'b0010
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   in_l,
  input  logic [15:0]                   in_r,
  input  logic                          in_stb,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [23:0]                   pkt_hb,
  output logic [223:0]                  pkt_sb,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUILD   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // IEC60958 channel-status bit for frame f of the 192-frame block.
  function automatic logic cs_bit(input logic [7:0] f);
    logic c;
    c = 1'b0;
    case (f)
      8'd2:    c = 1'b1;
      8'd24:   c = FS_CODE[0];
      8'd25:   c = FS_CODE[1];
      8'd26:   c = FS_CODE[2];
      8'd27:   c = FS_CODE[3];
      8'd32:   c = WL_CODE[0];
      8'd33:   c = WL_CODE[1];
      8'd34:   c = WL_CODE[2];
      8'd35:   c = WL_CODE[3];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Even parity over the 24-bit slot (low byte is zero), V=0, U=0 and C.
  function automatic logic even_parity(input logic [15:0] s, input logic c);
    return ^{s, c};
  endfunction

  // One 56-bit subpacket: L slot, R slot (LSB byte first), then status byte.
  function automatic logic [55:0] make_subpacket(input logic [15:0] l,
                                                 input logic [15:0] r,
                                                 input logic [7:0]  f);
    logic       c;
    logic [7:0] st;
    c  = cs_bit(f);
    st = {even_parity(r, c), c, 1'b0, 1'b0, even_parity(l, c), c, 1'b0, 1'b0};
    return {st, r, 8'h00, l, 8'h00};
  endfunction

  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          ovf_r;
  state_t        state_r;
  state_t        next_state_s;
  logic [2:0]    n_r;
  logic [2:0]    k_r;
  logic [7:0]    frame_r;
  logic [23:0]   hb_r;
  logic [223:0]  sb_r;
  logic          valid_r;

  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          latch_s;
  logic          drop_s;
  logic [2:0]    n_s;
  logic [31:0]   rd_data_s;

  assign full_s    = (level_r == LW'(FIFO_DEPTH));
  assign push_s    = in_stb && (!full_s || pop_s);
  assign drop_s    = in_stb && full_s && !pop_s;
  assign rd_data_s = mem_r[rd_ptr_r];
  assign n_s       = (level_r >= LW'(4)) ? 3'd4 : 3'(level_r);

  // FIFO storage and write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {in_l, in_r};
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // FIFO read pointer, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      level_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      ovf_r <= ovf_r | drop_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (level_r != '0) begin
          next_state_s = ST_BUILD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUILD: begin
        if ((k_r + 3'd1) == n_r) begin
          next_state_s = ST_PRESENT;
        end else begin
          next_state_s = ST_BUILD;
        end
      end
      ST_PRESENT: begin
        if (pkt_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_PRESENT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM control outputs: when to latch the group size and when to pop.
  always_comb begin
    latch_s = 1'b0;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE:    latch_s = (level_r != '0);
      ST_BUILD:   pop_s   = 1'b1;
      ST_PRESENT: pop_s   = 1'b0;
      default: begin
        latch_s = 1'b0;
        pop_s   = 1'b0;
      end
    endcase
  end

  // Packet shadow: cleared when a group is latched, filled one subpacket per pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r     <= 3'd0;
      k_r     <= 3'd0;
      frame_r <= 8'd0;
      hb_r    <= 24'h00_0000;
      sb_r    <= '0;
    end else if (latch_s) begin
      n_r  <= n_s;
      k_r  <= 3'd0;
      hb_r <= 24'h00_0000;
      sb_r <= '0;
    end else if (pop_s) begin
      sb_r[56*k_r[1:0] +: 56] <= make_subpacket(rd_data_s[31:16], rd_data_s[15:0], frame_r);
      hb_r[7:0]   <= 8'h02;
      hb_r[11:8]  <= hb_r[11:8] | (4'b0001 << k_r[1:0]);
      hb_r[23:20] <= hb_r[23:20] | ((frame_r == 8'd0) ? (4'b0001 << k_r[1:0]) : 4'b0000);
      k_r         <= k_r + 3'd1;
      frame_r     <= (frame_r == 8'd191) ? 8'd0 : frame_r + 8'd1;
    end else begin
      n_r <= n_r;
      k_r <= k_r;
    end
  end

  // Registered packet-valid, high exactly while the FSM sits in PRESENT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= (next_state_s == ST_PRESENT);
    end
  end

  assign pkt_valid  = valid_r;
  assign pkt_hb     = hb_r;
  assign pkt_sb     = sb_r;
  assign ovf        = ovf_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_hdmi_audio_packetizer.sv
// Self-checking bench for hdmi_audio_packetizer: accepted samples are queued
// as they are strobed in and compared against each packet the DUT presents.
module tb_hdmi_audio_packetizer;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_l;
  logic [15:0]  in_r;
  logic         in_stb;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [23:0]  pkt_hb;
  logic [223:0] pkt_sb;
  logic         ovf;
  logic [3:0]   fifo_level;

  int           checks   = 0;
  int           failures = 0;
  int           tb_frame = 0;
  int           b_seen   = 0;
  logic [31:0]  q[$];

  hdmi_audio_packetizer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_l(in_l), .in_r(in_r), .in_stb(in_stb),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_hb(pkt_hb),
    .pkt_sb(pkt_sb), .ovf(ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference subpacket from the channel-status table and a bitwise parity count.
  function automatic logic [55:0] sp_model(input logic [15:0] l, input logic [15:0] r, input int f);
    logic [63:0] cs;
    logic        c, pl, pr;
    cs        = 64'd0;
    cs[2]     = 1'b1;
    cs[27:24] = 4'b1110;
    cs[35:32] = 4'b0010;
    c  = (f < 64) ? cs[f] : 1'b0;
    pl = c;
    pr = c;
    for (int i = 0; i < 16; i++) begin
      pl = pl ^ l[i];
      pr = pr ^ r[i];
    end
    return {pr, c, 1'b0, 1'b0, pl, c, 1'b0, 1'b0, r, 8'h00, l, 8'h00};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    tb_frame = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle strobe; called at a negedge, returns at the next negedge.
  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    in_l   = l;
    in_r   = r;
    in_stb = 1'b1;
    if (q.size() < DEPTH) q.push_back({l, r});
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic accept_pkt(input string tag);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop: pkt_valid=%b expected 0", tag, pkt_valid);
    end
  endtask

  task automatic expect_packet(input int n, input bit accept, input string tag);
    int           waited;
    logic [23:0]  exp_hb;
    logic [223:0] exp_sb;
    logic [3:0]   sp, b;
    logic [31:0]  s;
    waited = 0;
    while (!pkt_valid && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    sp = 4'h0;
    b  = 4'h0;
    exp_sb = '0;
    for (int k = 0; k < n; k++) begin
      s = (q.size() > 0) ? q.pop_front() : 32'h0;
      exp_sb[k*56 +: 56] = sp_model(s[31:16], s[15:0], tb_frame);
      sp[k] = 1'b1;
      if (tb_frame == 0) b[k] = 1'b1;
      tb_frame = (tb_frame + 1) % 192;
    end
    exp_hb = {b, 4'h0, 4'h0, sp, 8'h02};
    checks++;
    if (!pkt_valid) begin
      failures++;
      $display("FAIL %s_timeout: pkt_valid=0 after %0d cycles, expected 1", tag, waited);
      return;
    end
    if (pkt_hb[20]) b_seen++;
    checks++;
    if (pkt_hb !== exp_hb) begin
      failures++;
      $display("FAIL %s_hb: got %h expected %h", tag, pkt_hb, exp_hb);
    end
    if (pkt_sb !== exp_sb) begin
      failures++;
      $display("FAIL %s_sb: got %h expected %h", tag, pkt_sb, exp_sb);
    end
    if (accept) accept_pkt(tag);
  endtask

  task automatic test_reset();
    checks++;
    if ({pkt_valid, pkt_hb, pkt_sb, ovf, fifo_level} !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b hb=%h ovf=%b level=%0d expected all 0",
               pkt_valid, pkt_hb, ovf, fifo_level);
    end
  endtask

  task automatic test_single();
    strobe(16'h1234, 16'hABCD);
    @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: pkt_valid=%b expected 0", pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: pkt_valid=%b expected 1", pkt_valid);
    end
    checks++;
    if (pkt_hb !== 24'h100102 || pkt_sb[47:0] !== 48'hABCD00_123400 || pkt_sb[223:56] !== '0) begin
      failures++;
      $display("FAIL single_fixed: hb=%h sb0=%h expected 100102 / ..ABCD00123400", pkt_hb, pkt_sb[55:0]);
    end
    expect_packet(1, 1'b1, "single");
  endtask

  task automatic test_handshake_hold();
    logic [23:0]  hb0;
    logic [223:0] sb0;
    bit           moved;
    int           waited;
    strobe(16'h5A5A, 16'h0F0F);
    waited = 0;
    while (!pkt_valid && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    hb0   = pkt_hb;
    sb0   = pkt_sb;
    moved = !pkt_valid;
    repeat (20) begin
      @(negedge clk);
      if (!pkt_valid || pkt_hb !== hb0 || pkt_sb !== sb0) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL hold_stable: packet changed or valid dropped, expected held for 20 cycles");
    end
    expect_packet(1, 1'b1, "hold");
  endtask

  task automatic test_burst();
    for (int i = 0; i < 6; i++) strobe(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    expect_packet(1, 1'b0, "burst1");
    checks++;
    if (pkt_hb[15:8] !== 8'h01) begin
      failures++;
      $display("FAIL burst_hb1a: got %h expected 01", pkt_hb[15:8]);
    end
    accept_pkt("burst1");
    expect_packet(4, 1'b0, "burst2");
    checks++;
    if (pkt_hb[15:8] !== 8'h0F || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL burst_hb1b: hb1=%h level=%0d expected 0F / 1", pkt_hb[15:8], fifo_level);
    end
    accept_pkt("burst2");
    expect_packet(1, 1'b1, "burst3");
  endtask

  task automatic test_overflow();
    strobe(16'h7777, 16'h8888);
    expect_packet(1, 1'b0, "ovf_park");
    for (int i = 0; i < DEPTH + 2; i++) strobe(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    checks++;
    if (ovf !== 1'b1 || fifo_level !== 4'(DEPTH)) begin
      failures++;
      $display("FAIL ovf_set: ovf=%b level=%0d expected 1 / %0d", ovf, fifo_level, DEPTH);
    end
    accept_pkt("ovf_park");
    expect_packet(4, 1'b1, "ovf_a");
    expect_packet(4, 1'b1, "ovf_b");
    repeat (4) @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || fifo_level !== 4'd0 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b level=%0d valid=%b expected 1 / 0 / 0", ovf, fifo_level, pkt_valid);
    end
  endtask

  task automatic test_reset_mid_build();
    strobe(16'h1111, 16'h2222);
    expect_packet(1, 1'b0, "rmb_park");
    for (int i = 0; i < 3; i++) strobe(16'h6000 + 16'(i), 16'h7000 + 16'(i));
    accept_pkt("rmb_park");
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pkt_valid, pkt_hb, pkt_sb, ovf, fifo_level} !== '0) begin
      failures++;
      $display("FAIL rmb_clear: valid=%b hb=%h ovf=%b level=%0d expected all 0",
               pkt_valid, pkt_hb, ovf, fifo_level);
    end
    q.delete();
    tb_frame = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    strobe(16'hCAFE, 16'hBEEF);
    expect_packet(1, 1'b0, "rmb_next");
    checks++;
    if (pkt_hb[20] !== 1'b1) begin
      failures++;
      $display("FAIL rmb_b0: B0=%b expected 1", pkt_hb[20]);
    end
    accept_pkt("rmb_next");
  endtask

  task automatic test_block_wrap();
    do_reset();
    b_seen = 0;
    for (int i = 0; i < 193; i++) begin
      strobe(16'($urandom), 16'($urandom));
      expect_packet(1, 1'b1, "wrap");
    end
    checks++;
    if (b_seen != 2) begin
      failures++;
      $display("FAIL wrap_bcount: B set in %0d packets expected 2", b_seen);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_l      = 16'h0;
    in_r      = 16'h0;
    in_stb    = 1'b0;
    pkt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    do_reset();
    test_single();
    test_handshake_hold();
    test_burst();
    test_overflow();
    test_reset_mid_build();
    test_block_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
